// File: rtl/gpu_ucode_sequencer_pkg.sv
// Shared definitions for the GPU microcode sequencer: uop field layout,
// opcode constants, sequencer state encodings and small decode helpers.
package gpu_ucode_sequencer_pkg;

  // Uop field layout: opcode in the top bits, jump target below it
  localparam int op_w    = 5;
  localparam int op_msb  = 19;
  localparam int op_lsb  = 15;
  localparam int tgt_msb = 14;
  localparam int tgt_lsb = 0;

  // Control-flow opcodes, resolved inside the sequencer
  localparam logic [op_w-1:0] op_gnop   = 5'h00;
  localparam logic [op_w-1:0] op_ggoto  = 5'h01;
  localparam logic [op_w-1:0] op_gjz    = 5'h02;
  localparam logic [op_w-1:0] op_gjnz   = 5'h03;

  // Long-latency opcodes, which hold the sequencer until the execute unit is done
  localparam logic [op_w-1:0] op_grvmem = 5'h04;
  localparam logic [op_w-1:0] op_gwbg   = 5'h05;

  // Single-issue ALU opcodes
  localparam logic [op_w-1:0] op_gwrl   = 5'h06;
  localparam logic [op_w-1:0] op_gsubl  = 5'h07;
  localparam logic [op_w-1:0] op_gaddl  = 5'h08;
  localparam logic [op_w-1:0] op_gandl  = 5'h09;
  localparam logic [op_w-1:0] op_gorl   = 5'h0A;
  localparam logic [op_w-1:0] op_gxorl  = 5'h0B;
  localparam logic [op_w-1:0] op_gmovl  = 5'h0C;

  // Highest defined opcode; anything above it is treated as a no-op
  localparam logic [op_w-1:0] op_last   = op_gmovl;

  typedef enum logic [1:0] {
    st_idle,
    st_fetch,
    st_issue,
    st_wait
  } seq_state_t;

  // True for opcodes the sequencer consumes itself (including undefined ones)
  function automatic logic is_control(input logic [op_w-1:0] op);
    return (op == op_gnop) || (op == op_ggoto) || (op == op_gjz) ||
           (op == op_gjnz) || (op > op_last);
  endfunction

  // True for opcodes whose completion is signalled later by the execute unit
  function automatic logic is_long(input logic [op_w-1:0] op);
    return (op == op_grvmem) || (op == op_gwbg);
  endfunction

endpackage

// File: rtl/gpu_branch_resolve.sv
// Next-PC selection for control-flow uops seen during FETCH. Anything that
// is not a taken jump simply advances the PC, wrapping modulo 2^ADDR_W.
module gpu_branch_resolve
  import gpu_ucode_sequencer_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int TGT_W  = 15
) (
  input  logic [op_w-1:0]   op,
  input  logic [TGT_W-1:0]  target,
  input  logic [ADDR_W-1:0] pc,
  input  logic              zero_flag,
  output logic [ADDR_W-1:0] next_pc
);

  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] jump_pc;
  logic              unused_target_hi;

  assign pc_inc           = pc + ADDR_W'(1);
  assign jump_pc          = target[ADDR_W-1:0];
  assign unused_target_hi = ^target[TGT_W-1:ADDR_W];

  // Pick the jump target for taken branches, otherwise fall through
  always_comb begin
    next_pc = pc_inc;
    case (op)
      op_ggoto: next_pc = jump_pc;
      op_gjz:   if (zero_flag)  next_pc = jump_pc;
      op_gjnz:  if (!zero_flag) next_pc = jump_pc;
      default:  next_pc = pc_inc;
    endcase
  end

endmodule

// File: rtl/gpu_ucode_sequencer.sv
// GPU microcode sequencer: walks the microcode ROM, resolves control-flow
// uops internally, issues everything else one at a time to the execute
// unit, and stalls on memory/writeback uops until the execute unit is done.
module gpu_ucode_sequencer
  import gpu_ucode_sequencer_pkg::*;
#(
  parameter int                ADDR_W   = 8,
  parameter int                UOP_W    = 20,
  parameter int                OP_W     = 5,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              iClock,
  input  logic              iReset,
  input  logic              iEnable,
  output logic [ADDR_W-1:0] oAddr,
  input  logic [UOP_W-1:0]  iUop,
  input  logic              iZeroFlag,
  input  logic              iDone,
  output logic [UOP_W-1:0]  oUop,
  output logic              oUopValid,
  output logic              oWaiting
);

  localparam int TGT_W = UOP_W - OP_W;

  seq_state_t        state;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] branch_pc;
  logic [UOP_W-1:0]  uop_q;
  logic              valid_q;
  logic              waiting_q;
  logic [OP_W-1:0]   fetch_op;
  logic [OP_W-1:0]   issue_op;

  assign fetch_op = iUop[UOP_W-1 -: OP_W];
  assign issue_op = uop_q[UOP_W-1 -: OP_W];

  gpu_branch_resolve #(
    .ADDR_W (ADDR_W),
    .TGT_W  (TGT_W)
  ) u_branch (
    .op        (fetch_op),
    .target    (iUop[TGT_W-1:0]),
    .pc        (pc_q),
    .zero_flag (iZeroFlag),
    .next_pc   (branch_pc)
  );

  // Sequencer FSM; dropping iEnable returns to IDLE from any state
  always_ff @(posedge iClock or negedge iReset) begin
    if (!iReset) begin
      state     <= st_idle;
      pc_q      <= RESET_PC;
      uop_q     <= '0;
      valid_q   <= 1'b0;
      waiting_q <= 1'b0;
    end else if (!iEnable) begin
      state     <= st_idle;
      pc_q      <= RESET_PC;
      valid_q   <= 1'b0;
      waiting_q <= 1'b0;
    end else begin
      case (state)
        st_idle: begin
          pc_q  <= RESET_PC;
          state <= st_fetch;
        end
        st_fetch: begin
          if (is_control(fetch_op)) begin
            pc_q <= branch_pc;
          end else begin
            uop_q   <= iUop;
            valid_q <= 1'b1;
            state   <= st_issue;
          end
        end
        st_issue: begin
          pc_q    <= pc_q + ADDR_W'(1);
          valid_q <= 1'b0;
          if (is_long(issue_op)) begin
            waiting_q <= 1'b1;
            state     <= st_wait;
          end else begin
            state <= st_fetch;
          end
        end
        st_wait: begin
          if (iDone) begin
            waiting_q <= 1'b0;
            state     <= st_fetch;
          end
        end
        default: begin
          state     <= st_idle;
          pc_q      <= RESET_PC;
          valid_q   <= 1'b0;
          waiting_q <= 1'b0;
        end
      endcase
    end
  end

  // The issue strobe is gated by iEnable so a falling enable suppresses it at once
  assign oAddr     = pc_q;
  assign oUop      = uop_q;
  assign oUopValid = valid_q & iEnable;
  assign oWaiting  = waiting_q;

endmodule

// File: tb/tb_gpu_ucode_sequencer.sv
// Testbench for gpu_ucode_sequencer: a behavioural ROM, per-cycle vector
// tables for address/strobe/wait expectations, and a scoreboard queue that
// checks every issued uop against the one the stimulus expected.
module tb_gpu_ucode_sequencer;
  import gpu_ucode_sequencer_pkg::*;

  typedef struct {
    string      name;
    logic       en;
    logic       z;
    logic       done;
    logic [7:0] addr;
    logic       valid;
    logic       waiting;
    logic [19:0] uop;
  } vec_t;

  logic        iClock;
  logic        iReset;
  logic        iEnable;
  logic [7:0]  oAddr;
  logic [19:0] iUop;
  logic        iZeroFlag;
  logic        iDone;
  logic [19:0] oUop;
  logic        oUopValid;
  logic        oWaiting;

  logic [19:0] rom [256];
  vec_t        vecs [$];
  logic [19:0] expQ [$];
  int          checks;
  int          errors;

  gpu_ucode_sequencer dut (
    .iClock    (iClock),
    .iReset    (iReset),
    .iEnable   (iEnable),
    .oAddr     (oAddr),
    .iUop      (iUop),
    .iZeroFlag (iZeroFlag),
    .iDone     (iDone),
    .oUop      (oUop),
    .oUopValid (oUopValid),
    .oWaiting  (oWaiting)
  );

  // Combinational microcode ROM
  assign iUop = rom[oAddr];

  // Free-running clock
  initial begin
    iClock = 1'b0;
    forever #5 iClock = ~iClock;
  end

  function automatic logic [19:0] mk(input logic [4:0] op, input logic [14:0] tgt);
    return {op, tgt};
  endfunction

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic checkOutput(input string name, input logic [7:0] addr,
                             input logic valid, input logic waiting);
    checkVal({name, ".addr"}, 32'(oAddr), 32'(addr));
    checkVal({name, ".valid"}, 32'(oUopValid), 32'(valid));
    checkVal({name, ".wait"}, 32'(oWaiting), 32'(waiting));
  endtask

  task automatic addVec(input string n, input logic en, input logic z, input logic done,
                        input logic [7:0] a, input logic v, input logic w, input logic [19:0] u);
    vec_t t;
    t.name = n; t.en = en; t.z = z; t.done = done;
    t.addr = a; t.valid = v; t.waiting = w; t.uop = u;
    vecs.push_back(t);
  endtask

  // Drive one table row per cycle on the falling edge and check the outputs
  task automatic applyStimulus();
    foreach (vecs[i]) begin
      @(negedge iClock);
      iEnable   = vecs[i].en;
      iZeroFlag = vecs[i].z;
      iDone     = vecs[i].done;
      if (vecs[i].valid) expQ.push_back(vecs[i].uop);
      #1;
      checkOutput(vecs[i].name, vecs[i].addr, vecs[i].valid, vecs[i].waiting);
    end
    vecs.delete();
  endtask

  // Scoreboard: every issue strobe must match the next expected uop
  always begin
    @(negedge iClock);
    #2;
    if (oUopValid === 1'b1) begin
      checks++;
      if (expQ.size() == 0) begin
        errors++;
        $display("[TB] FAIL sb_unexpected: got strobe with uop %0h expected no strobe", oUop);
      end else begin
        logic [19:0] e;
        e = expQ.pop_front();
        if (oUop !== e) begin
          errors++;
          $display("[TB] FAIL sb_uop: got %0h expected %0h", oUop, e);
        end
      end
    end
  end

  initial begin
    logic [4:0]  jop [4];
    logic        jz  [4];
    logic [7:0]  jex [4];
    checks = 0;
    errors = 0;
    iReset = 1'b0;
    iEnable = 1'b0;
    iZeroFlag = 1'b0;
    iDone = 1'b0;
    for (int i = 0; i < 256; i++) rom[i] = mk(op_gnop, 15'd0);

    // Reset values
    @(negedge iClock);
    #1;
    checkOutput("reset", 8'd0, 1'b0, 1'b0);
    checkVal("reset.uop", 32'(oUop), 32'd0);
    @(negedge iClock);
    iReset = 1'b1;

    // Straight-line fetch, one ALU issue, goto back to 0
    rom[0] = mk(op_gnop, 15'd0);
    rom[1] = mk(op_gwrl, 15'h123);
    rom[2] = mk(op_ggoto, 15'd0);
    addVec("t1_idle",   1, 0, 0, 8'd0, 0, 0, '0);
    addVec("t1_a0",     1, 0, 0, 8'd0, 0, 0, '0);
    addVec("t1_a1",     1, 0, 0, 8'd1, 0, 0, '0);
    addVec("t1_issue",  1, 0, 0, 8'd1, 1, 0, rom[1]);
    addVec("t1_a2",     1, 0, 0, 8'd2, 0, 0, '0);
    addVec("t1_a0b",    1, 0, 0, 8'd0, 0, 0, '0);
    addVec("t1_a1b",    1, 0, 0, 8'd1, 0, 0, '0);
    addVec("t1_issue2", 1, 0, 0, 8'd1, 1, 0, rom[1]);
    addVec("t1_drop",   0, 0, 0, 8'd2, 0, 0, '0);
    addVec("t1_idle2",  0, 0, 0, 8'd0, 0, 0, '0);
    applyStimulus();

    // Conditional branches after an ALU uop; entry goto uses 15'h0105 -> 5
    jop[0] = op_gjz;  jz[0] = 1'b1; jex[0] = 8'd20;
    jop[1] = op_gjz;  jz[1] = 1'b0; jex[1] = 8'd7;
    jop[2] = op_gjnz; jz[2] = 1'b1; jex[2] = 8'd7;
    jop[3] = op_gjnz; jz[3] = 1'b0; jex[3] = 8'd20;
    rom[0]  = mk(op_ggoto, 15'h0105);
    rom[5]  = mk(op_gsubl, 15'h0042);
    rom[7]  = mk(op_ggoto, 15'd7);
    rom[20] = mk(op_ggoto, 15'd20);
    for (int k = 0; k < 4; k++) begin
      rom[6] = mk(jop[k], 15'd20);
      addVec("br_idle",   1, ~jz[k], 0, 8'd0, 0, 0, '0);
      addVec("br_goto",   1, ~jz[k], 0, 8'd0, 0, 0, '0);
      addVec("br_subl",   1, ~jz[k], 0, 8'd5, 0, 0, '0);
      addVec("br_issue",  1,  jz[k], 0, 8'd5, 1, 0, rom[5]);
      addVec("br_jump",   1,  jz[k], 0, 8'd6, 0, 0, '0);
      addVec("br_target", 1,  jz[k], 0, jex[k], 0, 0, '0);
      addVec("br_spin",   1,  jz[k], 0, jex[k], 0, 0, '0);
      addVec("br_drop",   0,  jz[k], 0, jex[k], 0, 0, '0);
      addVec("br_idle2",  0,  jz[k], 0, 8'd0, 0, 0, '0);
      applyStimulus();
    end

    // Long-latency uop with spurious iDone before WAIT and a 7-cycle stall
    rom[0]  = mk(op_ggoto, 15'd10);
    rom[10] = mk(op_grvmem, 15'h00AB);
    rom[11] = mk(op_ggoto, 15'd11);
    addVec("rv_idle",  1, 0, 1, 8'd0, 0, 0, '0);
    addVec("rv_spur",  1, 0, 1, 8'd0, 0, 0, '0);
    addVec("rv_fetch", 1, 0, 0, 8'd10, 0, 0, '0);
    addVec("rv_issue", 1, 0, 1, 8'd10, 1, 0, rom[10]);
    for (int i = 0; i < 6; i++) addVec("rv_wait", 1, 0, 0, 8'd11, 0, 1, '0);
    addVec("rv_done",  1, 0, 1, 8'd11, 0, 1, '0);
    addVec("rv_resume",1, 0, 0, 8'd11, 0, 0, '0);
    addVec("rv_spin",  1, 0, 0, 8'd11, 0, 0, '0);
    addVec("rv_drop",  0, 0, 0, 8'd11, 0, 0, '0);
    addVec("rv_idle2", 0, 0, 0, 8'd0, 0, 0, '0);
    applyStimulus();

    // PC wrap at 255 and target 15'h7FFF; enable dropped during ISSUE
    rom[0]   = mk(op_ggoto, 15'h7FFF);
    rom[255] = mk(op_gwrl, 15'h0077);
    addVec("wr_idle",  1, 0, 0, 8'd0, 0, 0, '0);
    addVec("wr_goto",  1, 0, 0, 8'd0, 0, 0, '0);
    addVec("wr_f255",  1, 0, 0, 8'd255, 0, 0, '0);
    addVec("wr_issue", 1, 0, 0, 8'd255, 1, 0, rom[255]);
    addVec("wr_wrap",  1, 0, 0, 8'd0, 0, 0, '0);
    addVec("wr_f255b", 1, 0, 0, 8'd255, 0, 0, '0);
    addVec("wr_drop",  0, 0, 0, 8'd255, 0, 0, '0);
    addVec("wr_idle2", 0, 0, 0, 8'd0, 0, 0, '0);
    applyStimulus();

    // Enable dropped during WAIT, late iDone ignored, restart from 0
    rom[0] = mk(op_ggoto, 15'd10);
    addVec("ab_idle",   1, 0, 0, 8'd0, 0, 0, '0);
    addVec("ab_goto",   1, 0, 0, 8'd0, 0, 0, '0);
    addVec("ab_fetch",  1, 0, 0, 8'd10, 0, 0, '0);
    addVec("ab_issue",  1, 0, 0, 8'd10, 1, 0, rom[10]);
    addVec("ab_wait",   1, 0, 0, 8'd11, 0, 1, '0);
    addVec("ab_drop",   0, 0, 0, 8'd11, 0, 1, '0);
    addVec("ab_late",   0, 0, 1, 8'd0, 0, 0, '0);
    addVec("ab_idle",   0, 0, 0, 8'd0, 0, 0, '0);
    addVec("ab_reen",   1, 0, 0, 8'd0, 0, 0, '0);
    addVec("ab_goto2",  1, 0, 0, 8'd0, 0, 0, '0);
    addVec("ab_fetch2", 1, 0, 0, 8'd10, 0, 0, '0);
    addVec("ab_issue2", 1, 0, 0, 8'd10, 1, 0, rom[10]);
    addVec("ab_wait2",  1, 0, 0, 8'd11, 0, 1, '0);
    addVec("ab_done2",  1, 0, 1, 8'd11, 0, 1, '0);
    addVec("ab_resume", 1, 0, 0, 8'd11, 0, 0, '0);
    addVec("ab_drop2",  0, 0, 0, 8'd11, 0, 0, '0);
    addVec("ab_idle2",  0, 0, 0, 8'd0, 0, 0, '0);
    applyStimulus();

    // Undefined opcode behaves as a no-op and ignores its target field
    rom[0] = mk(5'h1F, 15'h0040);
    rom[1] = mk(op_ggoto, 15'd1);
    addVec("ud_idle",  1, 0, 0, 8'd0, 0, 0, '0);
    addVec("ud_op",    1, 0, 0, 8'd0, 0, 0, '0);
    addVec("ud_next",  1, 0, 0, 8'd1, 0, 0, '0);
    addVec("ud_spin",  1, 0, 0, 8'd1, 0, 0, '0);
    addVec("ud_drop",  0, 0, 0, 8'd1, 0, 0, '0);
    addVec("ud_idle2", 0, 0, 0, 8'd0, 0, 0, '0);
    applyStimulus();

    // Asynchronous reset in the middle of an ISSUE cycle
    rom[0] = mk(op_ggoto, 15'd3);
    rom[3] = mk(op_gwrl, 15'h0055);
    rom[4] = mk(op_ggoto, 15'd4);
    addVec("ar_idle",  1, 0, 0, 8'd0, 0, 0, '0);
    addVec("ar_goto",  1, 0, 0, 8'd0, 0, 0, '0);
    addVec("ar_fetch", 1, 0, 0, 8'd3, 0, 0, '0);
    applyStimulus();
    @(negedge iClock);
    iEnable = 1'b1;
    expQ.push_back(rom[3]);
    #1;
    checkOutput("ar_issue", 8'd3, 1'b1, 1'b0);
    #2;
    iReset = 1'b0;
    #1;
    checkOutput("ar_async", 8'd0, 1'b0, 1'b0);
    checkVal("ar_async.uop", 32'(oUop), 32'd0);
    @(negedge iClock);
    iReset  = 1'b1;
    iEnable = 1'b0;
    #1;
    checkOutput("ar_after", 8'd0, 1'b0, 1'b0);
    addVec("ar_reen",  1, 0, 0, 8'd0, 0, 0, '0);
    addVec("ar_goto2", 1, 0, 0, 8'd0, 0, 0, '0);
    addVec("ar_fetch2",1, 0, 0, 8'd3, 0, 0, '0);
    addVec("ar_issue2",1, 0, 0, 8'd3, 1, 0, rom[3]);
    addVec("ar_next",  1, 0, 0, 8'd4, 0, 0, '0);
    addVec("ar_drop",  0, 0, 0, 8'd4, 0, 0, '0);
    applyStimulus();

    @(negedge iClock);
    #3;
    checkVal("sb_drained", 32'(expQ.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
